// File: rtl/bus_decoder_ws_if.sv
// CPU-side bus bundle for bus_decoder_ws: strobes, address and attribute inputs,
// plus the decoded chip selects and boot-overlay status.
interface bus_decoder_ws_if;
   logic [5:0] i_A;
   logic       i_UDS_n;
   logic       i_LDS_n;
   logic       i_AS_n;
   logic       i_RW;
   logic       i_CPUSP_n;
   logic       i_LGEXP_n;
   logic       o_WR;
   logic       o_EVENRAM_n;
   logic       o_ODDRAM_n;
   logic       o_EVENROM_n;
   logic       o_ODDROM_n;
   logic       o_IOSEL_n;
   logic       o_EXPSEL_n;
   logic       o_BOOT;

   modport master (
      output i_A, i_UDS_n, i_LDS_n, i_AS_n, i_RW, i_CPUSP_n, i_LGEXP_n,
      input  o_WR, o_EVENRAM_n, o_ODDRAM_n, o_EVENROM_n, o_ODDROM_n,
             o_IOSEL_n, o_EXPSEL_n, o_BOOT
   );

   modport slave (
      input  i_A, i_UDS_n, i_LDS_n, i_AS_n, i_RW, i_CPUSP_n, i_LGEXP_n,
      output o_WR, o_EVENRAM_n, o_ODDRAM_n, o_EVENROM_n, o_ODDROM_n,
             o_IOSEL_n, o_EXPSEL_n, o_BOOT
   );
endinterface

// File: rtl/bus_decoder_ws.sv
// 68000 address decoder with per-region wait states, DTACK generation and boot overlay.
// Define BERR_TIMEOUT_EN to build in the bus-error watchdog on o_BERR_n.
//
// state | meaning
// IDLE  | waiting for a fresh AS assertion (E0)
// WAIT  | counting wait states down to DTACK
// ACK   | DTACK driven low until AS negates
// NOACK | unmapped cycle, DTACK left floating until AS negates
module bus_decoder_ws #(
   parameter int RAM_WS       = 0,
   parameter int ROM_WS       = 1,
   parameter int EXP_WS       = 2,
   parameter int IO_WS        = 3,
   parameter int WS_W         = 4,
   parameter int BOOT_CYCLES  = 4,
   parameter int BERR_TIMEOUT = 64
) (
   input  logic             i_CLK,
   input  logic             i_RESET_n,
   bus_decoder_ws_if.slave  bus,
   output wire              o_DTACK_n,
   output wire              o_BERR_n
);

   localparam int BC_W = $clog2(BOOT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_NOACK
   } state_t;

   state_t            state_q, state_d;
   logic [WS_W-1:0]   wsc_q, wsc_d;
   logic [BC_W-1:0]   bootcnt_q, bootcnt_d;
   logic              boot_q, boot_d;
   logic              as_q, as_d;
   logic              arm_q, arm_d;
   logic              rom_wr_q, rom_wr_d;
   logic              berr_act;

   logic [3:0]        a_hi;
   logic              ovl, rgn_ram, rgn_rom, rgn_io, rgn_exp;
   logic              sel_en, mapped, start;
   logic [WS_W-1:0]   ws_sel;

   assign a_hi    = bus.i_A[5:2];
   // Boot overlay only shadows reads of the lowest 256 KB.
   assign ovl     = boot_q & bus.i_RW & (bus.i_A == 6'd0);
   assign rgn_rom = (a_hi == 4'hE) | ovl;
   assign rgn_ram = (a_hi == 4'h0) & ~ovl;
   assign rgn_io  = (a_hi == 4'hF);
   assign rgn_exp = (a_hi != 4'h0) & (a_hi != 4'hE) & (a_hi != 4'hF);

   assign sel_en  = i_RESET_n & ~bus.i_AS_n & ~bus.i_CPUSP_n;
   assign mapped  = ~bus.i_CPUSP_n & ~(rgn_exp & bus.i_LGEXP_n);
   assign start   = (state_q == ST_IDLE) & as_q & arm_q & ~bus.i_AS_n;

   assign bus.o_WR        = ~bus.i_RW;
   assign bus.o_EVENRAM_n = ~(sel_en & rgn_ram & ~bus.i_UDS_n);
   assign bus.o_ODDRAM_n  = ~(sel_en & rgn_ram & ~bus.i_LDS_n);
   assign bus.o_EVENROM_n = ~(sel_en & rgn_rom & ~bus.i_UDS_n);
   assign bus.o_ODDROM_n  = ~(sel_en & rgn_rom & ~bus.i_LDS_n);
   assign bus.o_IOSEL_n   = ~(sel_en & rgn_io);
   assign bus.o_EXPSEL_n  = ~(sel_en & rgn_exp);
   assign bus.o_BOOT      = boot_q;

   assign o_DTACK_n = (state_q == ST_ACK) ? 1'b0 : 1'bz;

   always_comb begin
      ws_sel = WS_W'(EXP_WS);
      if (rgn_rom)      ws_sel = WS_W'(ROM_WS);
      else if (rgn_ram) ws_sel = WS_W'(RAM_WS);
      else if (rgn_io)  ws_sel = WS_W'(IO_WS);
   end

   always_comb begin
      state_d   = state_q;
      wsc_d     = wsc_q;
      bootcnt_d = bootcnt_q;
      boot_d    = boot_q;
      rom_wr_d  = rom_wr_q;
      as_d      = ~bus.i_AS_n;
      // A new cycle is only accepted after AS has been seen high since reset.
      arm_d     = arm_q | bus.i_AS_n;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rom_wr_d = (a_hi == 4'hE) & ~bus.i_RW;
               if (!mapped) begin
                  state_d = ST_NOACK;
               end else if (ws_sel == '0) begin
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_WAIT;
                  wsc_d   = ws_sel;
               end
            end
         end
         ST_WAIT: begin
            if (bus.i_AS_n) begin
               state_d = ST_IDLE;
               wsc_d   = '0;
            end else if (!berr_act) begin
               wsc_d = wsc_q - 1'b1;
               if (wsc_q == WS_W'(1)) state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (bus.i_AS_n) begin
               state_d = ST_IDLE;
               wsc_d   = '0;
               if (boot_q) begin
                  bootcnt_d = bootcnt_q + 1'b1;
                  if (rom_wr_q || (bootcnt_q == BC_W'(BOOT_CYCLES - 1))) boot_d = 1'b0;
               end
            end
         end
         ST_NOACK: begin
            if (bus.i_AS_n) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         state_q   <= ST_IDLE;
         wsc_q     <= '0;
         bootcnt_q <= '0;
         boot_q    <= 1'b1;
         as_q      <= 1'b0;
         arm_q     <= 1'b0;
         rom_wr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wsc_q     <= wsc_d;
         bootcnt_q <= bootcnt_d;
         boot_q    <= boot_d;
         as_q      <= as_d;
         arm_q     <= arm_d;
         rom_wr_q  <= rom_wr_d;
      end
   end

`ifdef BERR_TIMEOUT_EN
   localparam int TMO_W = $clog2(BERR_TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;

   assign berr_act = (tmo_q == TMO_W'(BERR_TIMEOUT)) & (state_q != ST_ACK);
   assign o_BERR_n = berr_act ? 1'b0 : 1'bz;

   always_comb begin
      tmo_d = tmo_q;
      if ((state_q == ST_IDLE) || bus.i_AS_n) begin
         tmo_d = '0;
      end else if ((state_q != ST_ACK) && (tmo_q != TMO_W'(BERR_TIMEOUT))) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RESET_n) begin
      if (!i_RESET_n) tmo_q <= '0;
      else            tmo_q <= tmo_d;
   end
`else
   wire unused_berr_timeout = (BERR_TIMEOUT > 0);

   assign berr_act = 1'b0;
   assign o_BERR_n = 1'bz;
`endif

endmodule

// File: tb/tb_bus_decoder_ws.sv
// Randomised and directed bench for bus_decoder_ws against a per-cycle reference model.
module tb_bus_decoder_ws;

   localparam int R_RAM = 0;
   localparam int R_ROM = 1;
   localparam int R_EXP = 2;
   localparam int R_IO  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   wire  dtack_n;
   wire  berr_n;

   pullup (dtack_n);
   pullup (berr_n);

   bus_decoder_ws_if bus ();

   bus_decoder_ws dut (
      .i_CLK     (clk),
      .i_RESET_n (rst_n),
      .bus       (bus),
      .o_DTACK_n (dtack_n),
      .o_BERR_n  (berr_n)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit boot_m;
   int bootcnt_m;

   task automatic check_val(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int region_of(input logic [5:0] a, input bit rw, input bit boot);
      logic [3:0] hi;
      hi = a[5:2];
      if (hi == 4'h0) return (boot && rw && a == 6'd0) ? R_ROM : R_RAM;
      if (hi == 4'hE) return R_ROM;
      if (hi == 4'hF) return R_IO;
      return R_EXP;
   endfunction

   // {evenram, oddram, evenrom, oddrom, iosel, expsel}, active low
   function automatic int exp_sel(input logic [5:0] a, input bit rw, input bit uds,
                                  input bit lds, input bit cpusp, input bit boot);
      int r;
      int v;
      if (cpusp) return 6'h3F;
      r = region_of(a, rw, boot);
      v = 6'h3F;
      if (r == R_RAM && !uds) v = v & ~32'h20;
      if (r == R_RAM && !lds) v = v & ~32'h10;
      if (r == R_ROM && !uds) v = v & ~32'h08;
      if (r == R_ROM && !lds) v = v & ~32'h04;
      if (r == R_IO)          v = v & ~32'h02;
      if (r == R_EXP)         v = v & ~32'h01;
      return v;
   endfunction

   function automatic int got_sel();
      return int'({bus.o_EVENRAM_n, bus.o_ODDRAM_n, bus.o_EVENROM_n,
                   bus.o_ODDROM_n, bus.o_IOSEL_n, bus.o_EXPSEL_n});
   endfunction

   task automatic bus_idle();
      bus.i_AS_n  = 1'b1;
      bus.i_UDS_n = 1'b1;
      bus.i_LDS_n = 1'b1;
   endtask

   // Starts at a falling edge, ends at a falling edge with the decoder idle.
   task automatic run_cycle(input logic [5:0] a, input bit rw, input bit uds, input bit lds,
                            input bit cpusp, input bit lgexp, input int abort_at, input int hold);
      int  r, ws, k, lows, berr_k, berr_exp;
      bit  mapped;
      r      = region_of(a, rw, boot_m);
      mapped = !cpusp && !(r == R_EXP && lgexp);
      ws     = (r == R_RAM) ? 0 : (r == R_ROM) ? 1 : (r == R_EXP) ? 2 : 3;

      bus.i_A       = a;
      bus.i_RW      = rw;
      bus.i_CPUSP_n = cpusp;
      bus.i_LGEXP_n = lgexp;
      bus.i_UDS_n   = uds;
      bus.i_LDS_n   = lds;
      bus.i_AS_n    = 1'b0;
      #1;
      check_val("sel", got_sel(), exp_sel(a, rw, uds, lds, cpusp, boot_m));
      check_val("wr", bus.o_WR, !rw);
      check_val("boot_mid", bus.o_BOOT, boot_m);
      @(posedge clk);
      @(negedge clk);
      check_val("pre_e0_dtack", dtack_n, 1);
      @(posedge clk);

      if (abort_at > 0) begin
         repeat (abort_at - 1) @(posedge clk);
         @(negedge clk);
         bus_idle();
         lows = 0;
         repeat (5) begin
            @(negedge clk);
            if (dtack_n == 1'b0) lows++;
         end
         check_val("abort_dtack", lows, 0);
      end else if (mapped) begin
         k = 0;
         while (k < 40) begin
            @(negedge clk);
            if (dtack_n == 1'b0) break;
            @(posedge clk);
            k++;
         end
         check_val("dtack_lat", k, ws);
         check_val("boot_ack", bus.o_BOOT, boot_m);
         @(posedge clk);
         @(negedge clk);
         check_val("dtack_hold", dtack_n, 0);
         bus_idle();
         @(posedge clk);
         @(negedge clk);
         check_val("dtack_rel", dtack_n, 1);
         if (boot_m) begin
            bootcnt_m++;
            if (bootcnt_m == 4 || (a[5:2] == 4'hE && !rw)) boot_m = 1'b0;
         end
      end else begin
         berr_k = -1;
         lows   = 0;
         for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            if (dtack_n == 1'b0) lows++;
            if (berr_n == 1'b0 && berr_k < 0) berr_k = i;
            if (i < hold) @(posedge clk);
         end
`ifdef BERR_TIMEOUT_EN
         berr_exp = (hold >= 64) ? 64 : -1;
`else
         berr_exp = -1;
`endif
         check_val("noack_dtack", lows, 0);
         check_val("berr_edge", berr_k, berr_exp);
         bus_idle();
         @(posedge clk);
         @(negedge clk);
         check_val("berr_rel", berr_n, 1);
      end
      check_val("boot_end", bus.o_BOOT, boot_m);
      check_val("sel_idle", got_sel(), 6'h3F);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [5:0] a;
      int         s;
      int         lows;
      bus.i_A       = 6'd0;
      bus.i_RW      = 1'b1;
      bus.i_CPUSP_n = 1'b0;
      bus.i_LGEXP_n = 1'b0;
      bus_idle();
      boot_m    = 1'b1;
      bootcnt_m = 0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_dtack", dtack_n, 1);
      check_val("rst_berr", berr_n, 1);
      check_val("rst_boot", bus.o_BOOT, 1);
      check_val("rst_sel", got_sel(), 6'h3F);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_cycle(6'b111100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
      for (int i = 0; i < 4; i++) run_cycle(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      check_val("boot_cleared", bus.o_BOOT, 0);
      run_cycle(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_cycle(6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      run_cycle(6'b111100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_cycle(6'b001100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_cycle(6'b001100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 6);
      run_cycle(6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 70);

      for (int n = 0; n < 40; n++) begin
         a = 6'($urandom_range(0, 63));
         s = $urandom_range(0, 2);
         run_cycle(a, 1'($urandom_range(0, 1)), (s == 2), (s == 1),
                   ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 0, 6);
      end

      bus.i_A       = 6'b111100;
      bus.i_RW      = 1'b1;
      bus.i_CPUSP_n = 1'b0;
      bus.i_UDS_n   = 1'b0;
      bus.i_LDS_n   = 1'b0;
      bus.i_AS_n    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_dtack", dtack_n, 1);
      check_val("mid_rst_sel", got_sel(), 6'h3F);
      check_val("mid_rst_boot", bus.o_BOOT, 1);
      boot_m    = 1'b1;
      bootcnt_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      lows  = 0;
      repeat (6) begin
         @(negedge clk);
         if (dtack_n == 1'b0) lows++;
      end
      check_val("no_fresh_edge", lows, 0);
      bus_idle();
      @(posedge clk);
      @(negedge clk);

      run_cycle(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_cycle(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      check_val("boot_before_romwr", bus.o_BOOT, 1);
      run_cycle(6'b111000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      check_val("boot_after_romwr", bus.o_BOOT, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
